// File: rtl/and4_rr_arbiter_pkg.sv
// Shared definitions for the AND4 round-robin arbiter: FSM state encoding
// and the operand width of the shared evaluator.
package and4_rr_arbiter_pkg;

    localparam int OP_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/and4_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: the winner is the first set request bit
// found scanning upward from the slot after the last grant, with wrap-around.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_i,
    output logic [ID_W-1:0]    win_o,
    output logic               any_o
);

    int idx_s;

    // Scan offsets 1..NUM_REQ from the last grant; first hit wins.
    always_comb begin
        any_o = 1'b0;
        win_o = '0;
        idx_s = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_s = (int'(last_i) + k) % NUM_REQ;
            if (!any_o && req_i[idx_s]) begin
                any_o = 1'b1;
                win_o = ID_W'(idx_s);
            end else begin
                any_o = any_o;
            end
        end
    end

endmodule

// File: rtl/nested_and4_example.sv
// Shared AND4 evaluator: a two-level AND tree over four single-bit inputs.
module nested_and4_example (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic y
);

    logic ab_s;
    logic cd_s;

    // Pairwise ANDs, then combine the two halves.
    always_comb begin
        ab_s = a & b;
        cd_s = c & d;
        y    = ab_s & cd_s;
    end

endmodule

// File: rtl/and4_rr_arbiter.sv
// Round-robin arbiter sharing one AND4 evaluator among NUM_REQ requesters.
// One transaction at a time: IDLE accepts, EVAL captures the result, RESP
// holds it until the consumer takes it.
module and4_rr_arbiter
    import and4_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int COUNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [OP_W*NUM_REQ-1:0] req_operand,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    rsp_result,
    input  logic                    rsp_ready,
    output logic                    busy,
    output logic [COUNT_W-1:0]      eval_count
);

    state_e              state_q, state_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ID_W-1:0]     last_q, last_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_result_q, rsp_result_d;
    logic                busy_q, busy_d;
    logic [COUNT_W-1:0]  count_q, count_d;
    logic [ID_W-1:0]     win_s;
    logic                any_s;
    logic                eval_y_s;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req_i  (req_valid),
        .last_i (last_q),
        .win_o  (win_s),
        .any_o  (any_s)
    );

    nested_and4_example u_and4 (
        .a (op_q[0]),
        .b (op_q[1]),
        .c (op_q[2]),
        .d (op_q[3]),
        .y (eval_y_s)
    );

    // Accept strobe: only the winner, and only while idle.
    always_comb begin
        req_ready = '0;
        if ((state_q == ST_IDLE) && any_s) begin
            req_ready[win_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Next-state and datapath updates for the accept/evaluate/respond cycle.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        id_d         = id_q;
        last_d       = last_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        count_d      = count_q;
        case (state_q)
            ST_IDLE: begin
                if (any_s) begin
                    op_d    = req_operand[int'(win_s)*OP_W +: OP_W];
                    id_d    = win_s;
                    last_d  = win_s;
                    state_d = ST_EVAL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EVAL: begin
                rsp_result_d = eval_y_s;
                rsp_valid_d  = 1'b1;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    count_d     = count_q + COUNT_W'(1);
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State registers; reset discards any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            id_q         <= '0;
            last_q       <= ID_W'(NUM_REQ - 1);
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= 1'b0;
            busy_q       <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            id_q         <= id_d;
            last_q       <= last_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            busy_q       <= busy_d;
            count_q      <= count_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = id_q;
    assign rsp_result = rsp_result_q;
    assign busy       = busy_q;
    assign eval_count = count_q;

endmodule

// File: tb/tb_and4_rr_arbiter.sv
// Scoreboard bench for and4_rr_arbiter: a transaction-level reference model
// predicts grants and results; a monitor compares every cycle.
module tb_and4_rr_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int CW  = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [4*N-1:0]  req_operand;
    logic [N-1:0]    req_ready;
    logic            rsp_valid;
    logic [IDW-1:0]  rsp_id;
    logic            rsp_result;
    logic            rsp_ready;
    logic            busy;
    logic [CW-1:0]   eval_count;

    and4_rr_arbiter #(.NUM_REQ(N), .ID_W(IDW), .COUNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_operand (req_operand),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_ready   (rsp_ready),
        .busy        (busy),
        .eval_count  (eval_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: phase 0 = free, 1 = accepted, 2 = response offered.
    int m_phase = 0;
    int m_last  = N - 1;
    int m_count = 0;
    int exp_id_q[$];
    bit exp_res_q[$];
    int grant_log[$];
    int res_log[$];

    function automatic int pick(input int last, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string nm);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout expected=completion at %0t", nm, $time);
    endtask

    // Model update at each clock edge / asynchronous reset.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_phase = 0;
                m_last  = N - 1;
                m_count = 0;
                exp_id_q.delete();
                exp_res_q.delete();
            end else begin
                if (m_phase == 0) begin
                    int w;
                    w = pick(m_last, req_valid);
                    if (w >= 0) begin
                        logic [3:0] op;
                        op = req_operand[4*w +: 4];
                        exp_id_q.push_back(w);
                        exp_res_q.push_back(op == 4'hF);
                        grant_log.push_back(w);
                        m_last  = w;
                        m_phase = 1;
                    end
                end else if (m_phase == 1) begin
                    m_phase = 2;
                end else if (rsp_ready) begin
                    m_phase = 0;
                    m_count = (m_count + 1) % 16;
                end
            end
        end
    end

    // Monitor: compares DUT outputs to the model away from the clock edge.
    initial begin
        forever begin
            logic [N-1:0] exp_ready;
            int w;
            @(negedge clk);
            #2;
            exp_ready = '0;
            if (m_phase == 0) begin
                w = pick(m_last, req_valid);
                if (w >= 0) exp_ready[w] = 1'b1;
            end
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
            chk("busy", 32'(busy), 32'(m_phase != 0));
            chk("eval_count", 32'(eval_count), 32'(m_count));
            if (rsp_valid === 1'b1) begin
                if (exp_id_q.size() == 0) begin
                    timeout_fail("rsp_unexpected");
                end else begin
                    chk("rsp_id", 32'(rsp_id), 32'(exp_id_q[0]));
                    chk("rsp_result", 32'(rsp_result), 32'(exp_res_q[0]));
                    if (rsp_ready && rst_n) begin
                        res_log.push_back(int'(rsp_result));
                        void'(exp_id_q.pop_front());
                        void'(exp_res_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic wait_busy(input bit want, input string nm);
        int n = 0;
        while (((m_phase != 0) != want) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if ((m_phase != 0) != want) timeout_fail(nm);
    endtask

    // One request pulse: hold valid until accepted, then wait for completion.
    task automatic txn(input logic [N-1:0] mask, input logic [4*N-1:0] ops);
        @(negedge clk);
        req_valid   = mask;
        req_operand = ops;
        rsp_ready   = 1'b1;
        wait_busy(1'b1, "txn_accept");
        req_valid = '0;
        wait_busy(1'b0, "txn_done");
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int fair_exp[5] = '{0, 1, 2, 3, 0};
    int fres_exp[5] = '{1, 0, 1, 0, 1};

    initial begin
        int n;
        rst_n       = 1'b0;
        req_valid   = '0;
        req_operand = '0;
        rsp_ready   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Basic: single requester, all-ones operand.
        grant_log.delete();
        res_log.delete();
        txn(4'b0001, 16'h000F);
        chk("basic_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
        chk("basic_result", (res_log.size() > 0) ? res_log[0] : -1, 1);
        chk("basic_count", 32'(eval_count), 1);

        // Reset while in EVAL: everything clears immediately.
        @(negedge clk);
        req_valid   = 4'hF;
        req_operand = 16'h7FEF;
        rsp_ready   = 1'b1;
        @(negedge clk);
        chk("rstmid_busy_pre", 32'(busy), 1);
        rst_n = 1'b0;
        #2;
        chk("rstmid_rsp_valid", 32'(rsp_valid), 0);
        chk("rstmid_busy", 32'(busy), 0);
        chk("rstmid_count", 32'(eval_count), 0);
        @(negedge clk);
        grant_log.delete();
        res_log.delete();
        rst_n = 1'b1;

        // Fairness: all valid after reset -> 0,1,2,3,0.
        n = 0;
        while (grant_log.size() < 5 && n < 40) begin
            @(negedge clk);
            n++;
        end
        req_valid = '0;
        wait_busy(1'b0, "fair_done");
        for (int i = 0; i < 5; i++) begin
            chk("fair_grant", (grant_log.size() > i) ? grant_log[i] : -1, fair_exp[i]);
            chk("fair_result", (res_log.size() > i) ? res_log[i] : -1, fres_exp[i]);
        end

        // Backpressure: response held 5 cycles while others request.
        @(negedge clk);
        req_valid   = 4'b0100;
        req_operand = 16'h0F00;
        rsp_ready   = 1'b0;
        wait_busy(1'b1, "bp_accept");
        req_valid = 4'hF;
        n = 0;
        while (m_phase != 2 && n < 10) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("bp_rsp_valid", 32'(rsp_valid), 1);
            chk("bp_req_ready", 32'(req_ready), 0);
            chk("bp_rsp_id", 32'(rsp_id), 2);
            chk("bp_rsp_result", 32'(rsp_result), 1);
        end
        @(negedge clk);
        req_valid = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_release_busy", 32'(busy), 0);

        // Wrap/skip of the grant pointer.
        grant_log.delete();
        txn(4'b1000, 16'h5000);
        txn(4'b0100, 16'h0300);
        txn(4'b0010, 16'h00F0);
        txn(4'b0010, 16'h00E0);
        chk("wrap_grant2", (grant_log.size() > 1) ? grant_log[1] : -1, 2);
        chk("skip_grant1", (grant_log.size() > 3) ? grant_log[3] : -1, 1);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            req_valid   = N'($urandom);
            req_operand = 16'($urandom);
            rsp_ready   = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_busy(1'b0, "rand_drain");

        // Counter wrap with a 4-bit counter.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            txn(N'($urandom_range(1, 15)), 16'($urandom));
            if (i == 14) chk("wrap_count15", 32'(eval_count), 15);
        end
        chk("wrap_count0", 32'(eval_count), 0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
